ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Two-requester arbiter in front of a simple dual-port RAM (one write
//   port, one registered read port). The write and read ports are arbitrated
//   independently, each with its own round-robin pointer. A write and a read
//   can therefore go to different requesters in the same cycle.
//
// Handshake: a request transfers in any cycle where req_valid[i] and
//   req_ready[i] are both 1. Request fields hold until that cycle.
//   req_ready is combinational. Read responses have no backpressure:
//   rsp_valid[i] pulses exactly one cycle after requester i's read grant,
//   and the requester must take it.
//
// Ports
//   clk, rst_n          single clock, asynchronous active-low reset
//   req_valid[1:0]      request present per requester
//   req_we[1:0]         1 = write, 0 = read, per requester
//   req_addr            requester i address at [i*A_WIDTH +: A_WIDTH]
//   req_wdata           requester i write data at [i*D_WIDTH +: D_WIDTH]
//   req_ready[1:0]      request of requester i accepted this cycle
//   rsp_valid[1:0]      read data for requester i on rsp_data
//   rsp_data            shared read-response data
//   ram_address_write, ram_data_write, ram_write_enable   RAM write port
//   ram_address_read, ram_data_read                       RAM read port
//                                                         (1-cycle latency)
//
// Configuration
//   RAM_ARB_FWD_EN  defined: same-address read+write granted in one cycle
//                   returns the new write data. Undefined: RAM
//                   read-before-write data is returned.
module ram_arbiter #(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  input  logic [1:0]           req_we,
  input  logic [2*A_WIDTH-1:0] req_addr,
  input  logic [2*D_WIDTH-1:0] req_wdata,
  output logic [1:0]           req_ready,
  output logic [1:0]           rsp_valid,
  output logic [D_WIDTH-1:0]   rsp_data,
  output logic [A_WIDTH-1:0]   ram_address_write,
  output logic [D_WIDTH-1:0]   ram_data_write,
  output logic                 ram_write_enable,
  output logic [A_WIDTH-1:0]   ram_address_read,
  input  logic [D_WIDTH-1:0]   ram_data_read
);

  logic [1:0] wcand, rcand;
  logic [1:0] wgnt, rgnt;
  logic       wptr_q, wptr_d;
  logic       rptr_q, rptr_d;
  logic [1:0] rd_owner_q, rd_owner_d;

  assign wcand = req_valid & req_we;
  assign rcand = req_valid & ~req_we;

  // Contention goes to the pointer; a lone requester always wins.
  // Grants are forced off while reset is asserted.
  always_comb begin
    wgnt = 2'b00;
    rgnt = 2'b00;
    if (rst_n) begin
      if (wcand == 2'b11) wgnt = wptr_q ? 2'b10 : 2'b01;
      else                wgnt = wcand;
      if (rcand == 2'b11) rgnt = rptr_q ? 2'b10 : 2'b01;
      else                rgnt = rcand;
    end
  end

  // After a grant to requester i the pointer moves to the other requester.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wgnt[0])      wptr_d = 1'b1;
    else if (wgnt[1]) wptr_d = 1'b0;
    if (rgnt[0])      rptr_d = 1'b1;
    else if (rgnt[1]) rptr_d = 1'b0;
    rd_owner_d = rgnt;
  end

  assign req_ready         = wgnt | rgnt;
  assign ram_write_enable  = |wgnt;
  assign ram_address_write = wgnt[1] ? req_addr[A_WIDTH +: A_WIDTH]
                                     : req_addr[0 +: A_WIDTH];
  assign ram_data_write    = wgnt[1] ? req_wdata[D_WIDTH +: D_WIDTH]
                                     : req_wdata[0 +: D_WIDTH];
  assign ram_address_read  = rgnt[1] ? req_addr[A_WIDTH +: A_WIDTH]
                                     : req_addr[0 +: A_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      rd_owner_q <= 2'b00;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // rd_owner_q is one-hot (or zero) because at most one read is granted.
  assign rsp_valid = rd_owner_q;

`ifdef RAM_ARB_FWD_EN
  // The RAM returns old contents when a read and a write hit the same
  // address in one cycle; capture the write data so the new value is
  // returned instead.
  logic               fwd_hit_q, fwd_hit_d;
  logic [D_WIDTH-1:0] fwd_data_q;

  assign fwd_hit_d = (|wgnt) && (|rgnt) &&
                     (ram_address_write == ram_address_read);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= ram_data_write;
    end
  end

  assign rsp_data = fwd_hit_q ? fwd_data_q : ram_data_read;
`else
  assign rsp_data = ram_data_read;
`endif

endmodule
